// File: rtl/decode_8b10b.sv
// 8b/10b receive decoder: one 10-bit symbol per clock in, registered byte,
// K flag, comma, code/disparity error flags and running disparity out one
// clock later, plus a saturating error counter for link-quality monitoring.
module decode_8b10b #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [9:0]           d_in,
    input  logic                 err_clr,
    output logic [7:0]           d_out,
    output logic                 k_out,
    output logic                 comma,
    output logic                 code_err,
    output logic                 disp_err,
    output logic                 rd_out,
    output logic [ERR_CNT_W-1:0] err_count
);

    // 6b abcdei -> {valid, EDCBA}; both disparity forms map to the same value
    function automatic logic [5:0] dec6(input logic [5:0] s);
        case (s)
            6'b100111, 6'b011000: dec6 = {1'b1, 5'd0};
            6'b011101, 6'b100010: dec6 = {1'b1, 5'd1};
            6'b101101, 6'b010010: dec6 = {1'b1, 5'd2};
            6'b110001:            dec6 = {1'b1, 5'd3};
            6'b110101, 6'b001010: dec6 = {1'b1, 5'd4};
            6'b101001:            dec6 = {1'b1, 5'd5};
            6'b011001:            dec6 = {1'b1, 5'd6};
            6'b111000, 6'b000111: dec6 = {1'b1, 5'd7};
            6'b111001, 6'b000110: dec6 = {1'b1, 5'd8};
            6'b100101:            dec6 = {1'b1, 5'd9};
            6'b010101:            dec6 = {1'b1, 5'd10};
            6'b110100:            dec6 = {1'b1, 5'd11};
            6'b001101:            dec6 = {1'b1, 5'd12};
            6'b101100:            dec6 = {1'b1, 5'd13};
            6'b011100:            dec6 = {1'b1, 5'd14};
            6'b010111, 6'b101000: dec6 = {1'b1, 5'd15};
            6'b011011, 6'b100100: dec6 = {1'b1, 5'd16};
            6'b100011:            dec6 = {1'b1, 5'd17};
            6'b010011:            dec6 = {1'b1, 5'd18};
            6'b110010:            dec6 = {1'b1, 5'd19};
            6'b001011:            dec6 = {1'b1, 5'd20};
            6'b101010:            dec6 = {1'b1, 5'd21};
            6'b011010:            dec6 = {1'b1, 5'd22};
            6'b111010, 6'b000101: dec6 = {1'b1, 5'd23};
            6'b110011, 6'b001100: dec6 = {1'b1, 5'd24};
            6'b100110:            dec6 = {1'b1, 5'd25};
            6'b010110:            dec6 = {1'b1, 5'd26};
            6'b110110, 6'b001001: dec6 = {1'b1, 5'd27};
            6'b001110:            dec6 = {1'b1, 5'd28};
            6'b101110, 6'b010001: dec6 = {1'b1, 5'd29};
            6'b011110, 6'b100001: dec6 = {1'b1, 5'd30};
            6'b101011, 6'b010100: dec6 = {1'b1, 5'd31};
            6'b001111, 6'b110000: dec6 = {1'b1, 5'd28};
            default:              dec6 = 6'b0;
        endcase
    endfunction

    // 4b fghj -> {valid, HGF}; P7 and A7 forms both decode to 7
    function automatic logic [3:0] dec4(input logic [3:0] s);
        case (s)
            4'b1011, 4'b0100: dec4 = {1'b1, 3'd0};
            4'b1001:          dec4 = {1'b1, 3'd1};
            4'b0101:          dec4 = {1'b1, 3'd2};
            4'b1100, 4'b0011: dec4 = {1'b1, 3'd3};
            4'b1101, 4'b0010: dec4 = {1'b1, 3'd4};
            4'b1010:          dec4 = {1'b1, 3'd5};
            4'b0110:          dec4 = {1'b1, 3'd6};
            4'b1110, 4'b0001,
            4'b0111, 4'b1000: dec4 = {1'b1, 3'd7};
            default:          dec4 = 4'b0;
        endcase
    endfunction

    function automatic logic [2:0] ones6(input logic [5:0] s);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < 6; i++) n = n + {2'b0, s[i]};
        return n;
    endfunction

    function automatic logic [2:0] ones4(input logic [3:0] s);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < 4; i++) n = n + {2'b0, s[i]};
        return n;
    endfunction

    logic [5:0] s6;
    logic [3:0] s4, s4_dec;
    logic [5:0] r6;
    logic [3:0] r4;
    logic [2:0] n6, n4;
    logic       k28, k7_ctx, a7, a7_ok;
    logic       rd6, de6, de4;

    logic [7:0]           d_out_d, d_out_q;
    logic                 k_out_d, k_out_q;
    logic                 comma_d, comma_q;
    logic                 code_err_d, code_err_q;
    logic                 disp_err_d, disp_err_q;
    logic                 rd_d, rd_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;

    // Symbol classification, table decode and running-disparity tracking
    always_comb begin
        s6 = d_in[9:4];
        s4 = d_in[3:0];
        k28 = (s6 == 6'b001111) || (s6 == 6'b110000);
        // K28 in its RD+ form carries the complemented 4b alternating codes
        s4_dec = (s6 == 6'b110000) ? ~s4 : s4;
        r6 = dec6(s6);
        r4 = dec4(s4_dec);
        n6 = ones6(s6);
        n4 = ones4(s4);

        // A7 is only legal after D17/18/20 (RD-), D11/13/14 (RD+) or a K.x.7
        a7 = (s4 == 4'b0111) || (s4 == 4'b1000);
        a7_ok = ((s4 == 4'b0111) &&
                 (s6 inside {6'b100011, 6'b010011, 6'b001011, 6'b000101,
                             6'b001001, 6'b010001, 6'b100001, 6'b110000})) ||
                ((s4 == 4'b1000) &&
                 (s6 inside {6'b110100, 6'b101100, 6'b011100, 6'b111010,
                             6'b110110, 6'b101110, 6'b011110, 6'b001111}));
        k7_ctx = s6 inside {6'b111010, 6'b000101, 6'b110110, 6'b001001,
                            6'b101110, 6'b010001, 6'b011110, 6'b100001};

        // 111000 is the RD- form of D7 and 000111 the RD+ form; same for 1100/0011
        de6 = ((n6 == 3'd4) && rd_q) || ((n6 == 3'd2) && !rd_q) ||
              ((s6 == 6'b111000) && rd_q) || ((s6 == 6'b000111) && !rd_q);
        rd6 = (n6 > 3'd3) ? 1'b1 : (n6 < 3'd3) ? 1'b0 : rd_q;
        de4 = ((n4 == 3'd3) && rd6) || ((n4 == 3'd1) && !rd6) ||
              ((s4 == 4'b1100) && rd6) || ((s4 == 4'b0011) && !rd6);
        // RD follows the received data even on error so the link resyncs
        rd_d = (n4 > 3'd2) ? 1'b1 : (n4 < 3'd2) ? 1'b0 : rd6;

        code_err_d = !r6[5] || !r4[3] || (a7 && !a7_ok);
        disp_err_d = de6 || de4;
        k_out_d    = !code_err_d && (k28 || (k7_ctx && a7));
        d_out_d    = {r4[2:0], r6[4:0]};
        comma_d    = (d_in[9:3] == 7'b0011111) || (d_in[9:3] == 7'b1100000);
    end

    // Output and running-disparity registers
    always_ff @(posedge clk) begin
        if (rst) begin
            d_out_q    <= '0;
            k_out_q    <= 1'b0;
            comma_q    <= 1'b0;
            code_err_q <= 1'b0;
            disp_err_q <= 1'b0;
            rd_q       <= 1'b0;
        end else begin
            d_out_q    <= d_out_d;
            k_out_q    <= k_out_d;
            comma_q    <= comma_d;
            code_err_q <= code_err_d;
            disp_err_q <= disp_err_d;
            rd_q       <= rd_d;
        end
    end

    // Saturating error counter fed by the registered flags; clear wins
    always_ff @(posedge clk) begin
        if (rst || err_clr) begin
            err_cnt_q <= '0;
        end else if ((code_err_q || disp_err_q) && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign d_out     = d_out_q;
    assign k_out     = k_out_q;
    assign comma     = comma_q;
    assign code_err  = code_err_q;
    assign disp_err  = disp_err_q;
    assign rd_out    = rd_q;
    assign err_count = err_cnt_q;

endmodule
